// File: rtl/instr_encoder_if.sv
// MIPS encoding constants plus the encoder's bus bundle: instruction field
// handshake in, instruction-memory write port out.
package mips_pkg;
    typedef enum logic [3:0] {
        NEM_ADD   = 4'd0,
        NEM_SUB   = 4'd1,
        NEM_AND   = 4'd2,
        NEM_OR    = 4'd3,
        NEM_XOR   = 4'd4,
        NEM_SLT   = 4'd5,
        NEM_ADDI  = 4'd6,
        NEM_ADDIU = 4'd7,
        NEM_LW    = 4'd8,
        NEM_SW    = 4'd9,
        NEM_BEQ   = 4'd10,
        NEM_JUMP  = 4'd11,
        NEM_ABS   = 4'd12,
        NEM_ZERO  = 4'd13
    } t_instr_pnmen;

    localparam logic [5:0] OP_ZERO  = 6'h00;
    localparam logic [5:0] OP_JUMP  = 6'h02;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_ABS   = 6'h1F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_ADD = 6'h20;
    localparam logic [5:0] FN_SUB = 6'h22;
    localparam logic [5:0] FN_AND = 6'h24;
    localparam logic [5:0] FN_OR  = 6'h25;
    localparam logic [5:0] FN_XOR = 6'h26;
    localparam logic [5:0] FN_SLT = 6'h2A;
endpackage

interface instr_encoder_if #(
    parameter int ADDR_W = 8
) ();
    logic                    in_valid;
    logic                    in_ready;
    mips_pkg::t_instr_pnmen  in_nem;
    logic [4:0]              in_rs;
    logic [4:0]              in_rt;
    logic [4:0]              in_rd;
    logic [15:0]             in_imm;
    logic [25:0]             in_target;
    logic                    in_last;
    logic                    imem_we;
    logic                    imem_ready;
    logic [ADDR_W-1:0]       imem_addr;
    logic [31:0]             imem_wdata;

    modport slave (
        input  in_valid, in_nem, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        output in_ready,
        output imem_we, imem_addr, imem_wdata,
        input  imem_ready
    );

    modport master (
        output in_valid, in_nem, in_rs, in_rt, in_rd, in_imm, in_target, in_last,
        input  in_ready,
        input  imem_we, imem_addr, imem_wdata,
        output imem_ready
    );
endinterface

// File: rtl/instr_encoder.sv
// Packs MIPS instruction fields into 32-bit words, buffers them in a small FIFO
// and streams them to instruction memory at consecutive word addresses.
module instr_encoder
    import mips_pkg::*;
#(
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 8
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_cfg_load,
    input  logic [ADDR_W-1:0] i_cfg_base,
    instr_encoder_if.slave    bus,
    output logic              o_done,
    output logic              o_err,
    output logic [ADDR_W-1:0] o_count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } t_state;

    t_state            r_state;
    t_state            w_next;
    logic [31:0]       r_mem [DEPTH];
    logic [PW-1:0]     r_wr_ptr;
    logic [PW-1:0]     r_rd_ptr;
    logic [CW-1:0]     r_fill;
    logic              r_we;
    logic [31:0]       r_wdata;
    logic [ADDR_W-1:0] r_addr;
    logic [ADDR_W-1:0] r_count;
    logic              r_err;

    logic [32:0]       w_enc;
    logic [CW-1:0]     w_occ;
    logic              w_in_ready;
    logic              w_accept;
    logic              w_push;
    logic              w_xfer;
    logic              w_pop;
    logic              w_fifo_empty;

    // Bit 32 flags a supported mnemonic; unsupported ones yield no word.
    function automatic logic [32:0] f_encode(
        input t_instr_pnmen nem,
        input logic [4:0]   rs,
        input logic [4:0]   rt,
        input logic [4:0]   rd,
        input logic [15:0]  imm,
        input logic [25:0]  tgt
    );
        logic [32:0] res;
        res = {1'b0, 32'h0000_0000};
        case (nem)
            NEM_ADD:   res = {1'b1, OP_ZERO, rs, rt, rd, 5'd0, FN_ADD};
            NEM_SUB:   res = {1'b1, OP_ZERO, rs, rt, rd, 5'd0, FN_SUB};
            NEM_AND:   res = {1'b1, OP_ZERO, rs, rt, rd, 5'd0, FN_AND};
            NEM_OR:    res = {1'b1, OP_ZERO, rs, rt, rd, 5'd0, FN_OR};
            NEM_XOR:   res = {1'b1, OP_ZERO, rs, rt, rd, 5'd0, FN_XOR};
            NEM_SLT:   res = {1'b1, OP_ZERO, rs, rt, rd, 5'd0, FN_SLT};
            NEM_ADDI:  res = {1'b1, OP_ADDI, rs, rt, imm};
            NEM_ADDIU: res = {1'b1, OP_ADDIU, rs, rt, imm};
            NEM_LW:    res = {1'b1, OP_LW, rs, rt, imm};
            NEM_SW:    res = {1'b1, OP_SW, rs, rt, imm};
            NEM_BEQ:   res = {1'b1, OP_BEQ, rs, rt, imm};
            NEM_JUMP:  res = {1'b1, OP_JUMP, tgt};
            // ABS writes rt because the decoder drives RegDst=0 for it.
            NEM_ABS:   res = {1'b1, OP_ABS, rs, rt, 16'h0000};
            NEM_ZERO:  res = {1'b1, 32'h0000_0000};
            default:   res = {1'b0, 32'h0000_0000};
        endcase
        return res;
    endfunction

    // The output register counts toward capacity so that at most DEPTH words are in flight.
    assign w_occ        = r_fill + CW'(r_we);
    assign w_in_ready   = (r_state == S_RUN) && (w_occ < CW'(DEPTH));
    assign w_accept     = bus.in_valid && w_in_ready;
    assign w_enc        = f_encode(bus.in_nem, bus.in_rs, bus.in_rt, bus.in_rd,
                                   bus.in_imm, bus.in_target);
    assign w_push       = w_accept && w_enc[32];
    assign w_xfer       = r_we && bus.imem_ready;
    assign w_fifo_empty = (r_fill == CW'(0));
    assign w_pop        = !w_fifo_empty && (!r_we || w_xfer);

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Next-state logic; DRAIN exits on the cycle of the final transfer.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (i_cfg_load) w_next = S_RUN;
                else            w_next = S_IDLE;
            end
            S_RUN: begin
                if (w_accept && bus.in_last) w_next = S_DRAIN;
                else                         w_next = S_RUN;
            end
            S_DRAIN: begin
                if (w_fifo_empty && (!r_we || w_xfer)) w_next = S_DONE;
                else                                   w_next = S_DRAIN;
            end
            S_DONE:  w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // FIFO storage; contents are don't-care while the pointers say empty.
    always_ff @(posedge i_clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= w_enc[31:0];
        end
    end

    // FIFO pointers, output stage, address/count and sticky error.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_fill   <= '0;
            r_we     <= 1'b0;
            r_wdata  <= 32'h0000_0000;
            r_addr   <= '0;
            r_count  <= '0;
            r_err    <= 1'b0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
            if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
            r_fill <= r_fill + CW'(w_push) - CW'(w_pop);

            if (w_pop) begin
                r_we    <= 1'b1;
                r_wdata <= r_mem[r_rd_ptr];
            end else if (w_xfer) begin
                r_we    <= 1'b0;
            end

            if ((r_state == S_IDLE) && i_cfg_load) begin
                r_addr  <= i_cfg_base;
                r_count <= '0;
            end else if (w_xfer) begin
                r_addr  <= r_addr + ADDR_W'(1);
                r_count <= r_count + ADDR_W'(1);
            end

            if ((r_state == S_IDLE) && i_cfg_load) begin
                r_err <= 1'b0;
            end else if (w_accept && !w_enc[32]) begin
                r_err <= 1'b1;
            end
        end
    end

    assign bus.in_ready   = w_in_ready;
    assign bus.imem_we    = r_we;
    assign bus.imem_addr  = r_addr;
    assign bus.imem_wdata = r_wdata;
    assign o_done         = (r_state == S_DONE);
    assign o_err          = r_err;
    assign o_count        = r_count;
endmodule

// File: tb/tb_instr_encoder.sv
// Directed bench for instr_encoder: table of encodings plus hand-written
// backpressure, wrap, error and mid-program reset sequences.
module tb_instr_encoder;
    import mips_pkg::*;

    localparam int AW = 8;

    typedef struct {
        t_instr_pnmen nem;
        logic [4:0]   rs;
        logic [4:0]   rt;
        logic [4:0]   rd;
        logic [15:0]  imm;
        logic [25:0]  tgt;
        logic [31:0]  exp;
    } vec_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          cfg_load = 1'b0;
    logic [AW-1:0] cfg_base = '0;
    logic          o_done;
    logic          o_err;
    logic [AW-1:0] o_count;

    int checks = 0;
    int errors = 0;
    int cyc_cnt = 0;
    int done_cnt = 0;
    logic [AW-1:0] done_count_val = '0;
    logic [AW-1:0] got_addr[$];
    logic [31:0]   got_data[$];
    int            got_cyc[$];
    vec_t          vt[13];

    instr_encoder_if #(.ADDR_W(AW)) bus ();

    instr_encoder #(.DEPTH(4), .ADDR_W(AW)) dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_cfg_load (cfg_load),
        .i_cfg_base (cfg_base),
        .bus        (bus),
        .o_done     (o_done),
        .o_err      (o_err),
        .o_count    (o_count)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Log every write transfer and done pulse, sampled mid-low-phase.
    always @(negedge clk) begin
        #1;
        if (bus.imem_we && bus.imem_ready) begin
            got_addr.push_back(bus.imem_addr);
            got_data.push_back(bus.imem_wdata);
            got_cyc.push_back(cyc_cnt);
        end
        if (o_done) begin
            done_cnt = done_cnt + 1;
            done_count_val = o_count;
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            errors = errors + 1;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic clear_log();
        got_addr.delete();
        got_data.delete();
        got_cyc.delete();
    endtask

    task automatic cfg_start(input logic [AW-1:0] base);
        cfg_base = base;
        cfg_load = 1'b1;
        @(negedge clk);
        cfg_load = 1'b0;
    endtask

    task automatic send(input t_instr_pnmen nem, input logic [4:0] rs, input logic [4:0] rt,
                        input logic [4:0] rd, input logic [15:0] imm, input logic [25:0] tgt,
                        input logic last);
        int n;
        bus.in_nem    = nem;
        bus.in_rs     = rs;
        bus.in_rt     = rt;
        bus.in_rd     = rd;
        bus.in_imm    = imm;
        bus.in_target = tgt;
        bus.in_last   = last;
        bus.in_valid  = 1'b1;
        n = 0;
        while (!bus.in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!bus.in_ready) chk("send_timeout", 32'd0, 32'd1);
        else               @(posedge clk);
        @(negedge clk);
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    // Waits for one done pulse, then confirms it lasted exactly one cycle.
    task automatic wait_done(input string nm);
        int n;
        int d0;
        d0 = done_cnt;
        n = 0;
        while (done_cnt == d0 && n < 300) begin
            @(negedge clk);
            n++;
        end
        repeat (3) @(negedge clk);
        chk({nm, "_done_pulses"}, 32'(done_cnt - d0), 32'd1);
    endtask

    initial begin
        vt[0]  = '{NEM_ADDI,  5'd0,  5'd8,  5'd0,  16'h0005, 26'h0,       32'h2008_0005};
        vt[1]  = '{NEM_LW,    5'd29, 5'd9,  5'd0,  16'h0004, 26'h0,       32'h8FA9_0004};
        vt[2]  = '{NEM_BEQ,   5'd1,  5'd2,  5'd0,  16'hFFFF, 26'h0,       32'h1022_FFFF};
        vt[3]  = '{NEM_JUMP,  5'd0,  5'd0,  5'd0,  16'h0000, 26'h0100000, 32'h0810_0000};
        vt[4]  = '{NEM_SUB,   5'd4,  5'd5,  5'd6,  16'hFFFF, 26'h0,       32'h0085_3022};
        vt[5]  = '{NEM_AND,   5'd7,  5'd8,  5'd9,  16'h0000, 26'h0,       32'h00E8_4824};
        vt[6]  = '{NEM_OR,    5'd10, 5'd11, 5'd12, 16'h0000, 26'h0,       32'h014B_6025};
        vt[7]  = '{NEM_XOR,   5'd31, 5'd31, 5'd31, 16'h0000, 26'h0,       32'h03FF_F826};
        vt[8]  = '{NEM_SLT,   5'd1,  5'd2,  5'd3,  16'h0000, 26'h0,       32'h0022_182A};
        vt[9]  = '{NEM_ADDIU, 5'd3,  5'd4,  5'd0,  16'h8000, 26'h0,       32'h2464_8000};
        vt[10] = '{NEM_SW,    5'd29, 5'd31, 5'd0,  16'h0010, 26'h0,       32'hAFBF_0010};
        vt[11] = '{NEM_ABS,   5'd5,  5'd6,  5'd7,  16'h1234, 26'h0,       32'h7CA6_0000};
        vt[12] = '{NEM_ZERO,  5'd9,  5'd9,  5'd9,  16'hABCD, 26'h3FFFFFF, 32'h0000_0000};

        bus.in_valid = 1'b0;
        bus.in_nem = NEM_ZERO;
        bus.in_rs = '0;
        bus.in_rt = '0;
        bus.in_rd = '0;
        bus.in_imm = '0;
        bus.in_target = '0;
        bus.in_last = 1'b0;
        bus.imem_ready = 1'b1;

        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
        chk("rst_we", 32'(bus.imem_we), 32'd0);
        chk("rst_addr", 32'(bus.imem_addr), 32'd0);
        chk("rst_wdata", bus.imem_wdata, 32'd0);
        chk("rst_done", 32'(o_done), 32'd0);
        chk("rst_err", 32'(o_err), 32'd0);
        chk("rst_count", 32'(o_count), 32'd0);

        // Single ADD with latency check
        clear_log();
        cfg_start(8'h10);
        chk("t1_in_ready", 32'(bus.in_ready), 32'd1);
        send(NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0000, 26'h0, 1'b1);
        chk("t1_we_early", 32'(bus.imem_we), 32'd0);
        @(negedge clk);
        chk("t1_we_lat", 32'(bus.imem_we), 32'd1);
        chk("t1_data_lat", bus.imem_wdata, 32'h0022_1820);
        wait_done("t1");
        chk("t1_nwrites", 32'(got_data.size()), 32'd1);
        if (got_data.size() == 1) begin
            chk("t1_addr", 32'(got_addr[0]), 32'h10);
            chk("t1_data", got_data[0], 32'h0022_1820);
        end
        chk("t1_count", 32'(done_count_val), 32'd1);

        // Encoding table, streamed back to back
        clear_log();
        cfg_start(8'h20);
        for (int i = 0; i < 13; i++) begin
            send(vt[i].nem, vt[i].rs, vt[i].rt, vt[i].rd, vt[i].imm, vt[i].tgt, i == 12);
        end
        wait_done("tab");
        chk("tab_nwrites", 32'(got_data.size()), 32'd13);
        if (got_data.size() == 13) begin
            for (int i = 0; i < 13; i++) begin
                chk($sformatf("tab_data_%0d", i), got_data[i], vt[i].exp);
                chk($sformatf("tab_addr_%0d", i), 32'(got_addr[i]), 32'h20 + 32'(i));
                chk($sformatf("tab_cycle_%0d", i), 32'(got_cyc[i] - got_cyc[0]), 32'(i));
            end
        end
        chk("tab_count", 32'(done_count_val), 32'd13);
        chk("tab_err", 32'(o_err), 32'd0);

        // Backpressure: 6 pushes against a stalled memory
        begin
            int idx;
            logic rdy;
            clear_log();
            cfg_start(8'h40);
            bus.imem_ready = 1'b0;
            idx = 0;
            for (int cyc = 0; cyc < 60 && idx < 6; cyc++) begin
                if (cyc == 3 || cyc == 7) begin
                    chk("bp_hold_we", 32'(bus.imem_we), 32'd1);
                    chk("bp_hold_data", bus.imem_wdata, 32'h2008_0001);
                    chk("bp_hold_addr", 32'(bus.imem_addr), 32'h40);
                end
                if (cyc == 7) begin
                    chk("bp_accepts", 32'(idx), 32'd4);
                    chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
                end
                bus.imem_ready = (cyc >= 8);
                bus.in_nem = NEM_ADDI;
                bus.in_rs = 5'd0;
                bus.in_rt = 5'd8;
                bus.in_imm = 16'(idx + 1);
                bus.in_last = (idx == 5);
                bus.in_valid = 1'b1;
                rdy = bus.in_ready;
                @(posedge clk);
                if (rdy) idx++;
                @(negedge clk);
            end
            bus.in_valid = 1'b0;
            bus.in_last = 1'b0;
            chk("bp_all_accepted", 32'(idx), 32'd6);
            wait_done("bp");
            chk("bp_nwrites", 32'(got_data.size()), 32'd6);
            if (got_data.size() == 6) begin
                for (int i = 0; i < 6; i++) begin
                    chk($sformatf("bp_data_%0d", i), got_data[i], 32'h2008_0000 + 32'(i + 1));
                    chk($sformatf("bp_addr_%0d", i), 32'(got_addr[i]), 32'h40 + 32'(i));
                end
            end
            chk("bp_count", 32'(done_count_val), 32'd6);
        end

        // Address wrap
        clear_log();
        cfg_start(8'hFE);
        for (int i = 0; i < 3; i++) send(NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, i == 2);
        wait_done("wrap");
        chk("wrap_nwrites", 32'(got_data.size()), 32'd3);
        if (got_addr.size() == 3) begin
            chk("wrap_addr0", 32'(got_addr[0]), 32'hFE);
            chk("wrap_addr1", 32'(got_addr[1]), 32'hFF);
            chk("wrap_addr2", 32'(got_addr[2]), 32'h00);
        end
        chk("wrap_count", 32'(done_count_val), 32'd3);

        // Unsupported mnemonic between two ADDs
        clear_log();
        cfg_start(8'h50);
        send(NEM_ADD, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        chk("err_before", 32'(o_err), 32'd0);
        send(t_instr_pnmen'(4'd15), 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b0);
        chk("err_set", 32'(o_err), 32'd1);
        send(NEM_SLT, 5'd1, 5'd2, 5'd3, 16'h0, 26'h0, 1'b1);
        wait_done("err");
        chk("err_nwrites", 32'(got_data.size()), 32'd2);
        if (got_data.size() == 2) begin
            chk("err_data0", got_data[0], 32'h0022_1820);
            chk("err_data1", got_data[1], 32'h0022_182A);
            chk("err_addr1", 32'(got_addr[1]), 32'h51);
        end
        chk("err_count", 32'(done_count_val), 32'd2);
        chk("err_sticky", 32'(o_err), 32'd1);

        // Unsupported mnemonic carrying in_last
        clear_log();
        cfg_start(8'h60);
        chk("errlast_cleared", 32'(o_err), 32'd0);
        send(t_instr_pnmen'(4'd14), 5'd0, 5'd0, 5'd0, 16'h0, 26'h0, 1'b1);
        wait_done("errlast");
        chk("errlast_nwrites", 32'(got_data.size()), 32'd0);
        chk("errlast_err", 32'(o_err), 32'd1);
        chk("errlast_count", 32'(done_count_val), 32'd0);

        // Reset with 3 words buffered
        begin
            int d0;
            clear_log();
            cfg_start(8'h70);
            bus.imem_ready = 1'b0;
            for (int i = 0; i < 3; i++) send(NEM_ADDI, 5'd0, 5'd8, 5'd0, 16'(i + 9), 26'h0, 1'b0);
            chk("mid_we_before", 32'(bus.imem_we), 32'd1);
            d0 = done_cnt;
            rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
            chk("mid_we", 32'(bus.imem_we), 32'd0);
            chk("mid_in_ready", 32'(bus.in_ready), 32'd0);
            chk("mid_addr", 32'(bus.imem_addr), 32'd0);
            chk("mid_wdata", bus.imem_wdata, 32'd0);
            chk("mid_count", 32'(o_count), 32'd0);
            bus.imem_ready = 1'b1;
            repeat (6) @(negedge clk);
            chk("mid_nwrites", 32'(got_data.size()), 32'd0);
            chk("mid_no_done", 32'(done_cnt - d0), 32'd0);
            cfg_start(8'h30);
            send(NEM_ADDI, 5'd0, 5'd8, 5'd0, 16'h0007, 26'h0, 1'b1);
            wait_done("post");
            chk("post_nwrites", 32'(got_data.size()), 32'd1);
            if (got_data.size() == 1) begin
                chk("post_data", got_data[0], 32'h2008_0007);
                chk("post_addr", 32'(got_addr[0]), 32'h30);
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
